// File: rtl/decode_pkg.sv
// Shared types and constants for the decode issue sequencer.
package decode_pkg;
    localparam int INSTR_WIDTH = 16;
    typedef logic [INSTR_WIDTH-1:0] instr_t;
    localparam instr_t NOP_INSTR = 16'h000F;
    typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_UOP} issue_src_e;
endpackage

// File: rtl/uop_fifo.sv
// Micro-op FIFO with combinational head, synchronous clear; 1-cycle push-to-visible.
// No backpressure: a push while full with no pop is dropped and flagged on drop_o.
module uop_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             drop_o
);
    // Storage rounded up to a power of two so pointer indexing is always in range.
    localparam int MEM_N = 1 << PTR_W;

    logic [WIDTH-1:0] mem [MEM_N];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign dat_o   = mem[rd_ptr];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem[wr_ptr] <= dat_i;
    end
endmodule

// File: rtl/decode_issue_seq.sv
// Merges fetch with delayed micro-ops (uops win) into one registered issue slot; fetch->issue 1 cycle,
// uop_push->FIFO UOP_DELAY+1 cycles. fetch_ready_o drops on stall, flush or any queued uop.
module decode_issue_seq import decode_pkg::*; #(
    parameter int INSTR_W = 16,
    parameter int PC_W = 32,
    parameter int UOP_DELAY = 2,
    parameter int UOP_DEPTH = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = decode_pkg::NOP_INSTR
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             fetch_valid_i,
    output logic                             fetch_ready_o,
    input  logic [INSTR_W-1:0]               fetch_instr_i,
    input  logic [PC_W-1:0]                  fetch_pc_i,
    input  logic [PC_W-1:0]                  fetch_npc_i,
    input  logic                             uop_push_i,
    input  logic [INSTR_W-1:0]               uop_i,
    input  logic                             stall_i,
    input  logic                             flush_i,
    output logic                             issue_valid_o,
    output logic [INSTR_W-1:0]               issue_instr_o,
    output logic [PC_W-1:0]                  issue_pc_o,
    output logic [PC_W-1:0]                  issue_npc_o,
    output logic                             issue_is_uop_o,
    output logic [$clog2(UOP_DEPTH+1)-1:0]   uop_count_o,
    output logic                             uop_full_o,
    output logic                             uop_overflow_o
);
    logic               advance;
    logic               enq_vld;
    logic [INSTR_W-1:0] enq_dat;
    logic [INSTR_W-1:0] fifo_dat;
    logic               fifo_empty;
    logic               fifo_drop;
    issue_src_e         src;

    assign advance       = !stall_i && !flush_i;
    assign fetch_ready_o = advance && fifo_empty;

    if (UOP_DELAY == 0) begin : g_direct
        assign enq_vld = uop_push_i && advance;
        assign enq_dat = uop_i;
    end else begin : g_delay
        logic               stg_vld [UOP_DELAY];
        logic [INSTR_W-1:0] stg_dat [UOP_DELAY];

        for (genvar s = 0; s < UOP_DELAY; s++) begin : g_stage
            logic               in_vld, vld_q;
            logic [INSTR_W-1:0] in_dat, dat_q;

            if (s == 0) begin : g_first
                assign in_vld = uop_push_i;
                assign in_dat = uop_i;
            end else begin : g_next
                assign in_vld = stg_vld[s-1];
                assign in_dat = stg_dat[s-1];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else if (flush_i) begin
                    vld_q <= 1'b0;
                end else if (!stall_i) begin
                    vld_q <= in_vld;
                    dat_q <= in_dat;
                end
            end

            assign stg_vld[s] = vld_q;
            assign stg_dat[s] = dat_q;
        end

        assign enq_vld = stg_vld[UOP_DELAY-1] && advance;
        assign enq_dat = stg_dat[UOP_DELAY-1];
    end

    uop_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (UOP_DEPTH)
    ) u_uop_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (flush_i),
        .push_i  (enq_vld),
        .dat_i   (enq_dat),
        .pop_i   (advance),
        .dat_o   (fifo_dat),
        .full_o  (uop_full_o),
        .empty_o (fifo_empty),
        .count_o (uop_count_o),
        .drop_o  (fifo_drop)
    );

    always_comb begin
        src = SRC_NONE;
        if (!fifo_empty)                           src = SRC_UOP;
        else if (fetch_valid_i && fetch_ready_o)   src = SRC_FETCH;
    end

    // A uop keeps the PC/NPC of the instruction that spawned it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_valid_o  <= 1'b0;
            issue_instr_o  <= NOP_INSTR;
            issue_pc_o     <= '0;
            issue_npc_o    <= '0;
            issue_is_uop_o <= 1'b0;
        end else if (flush_i) begin
            issue_valid_o  <= 1'b0;
            issue_instr_o  <= NOP_INSTR;
            issue_is_uop_o <= 1'b0;
        end else if (!stall_i) begin
            unique case (src)
                SRC_UOP: begin
                    issue_valid_o  <= 1'b1;
                    issue_instr_o  <= fifo_dat;
                    issue_is_uop_o <= 1'b1;
                end
                SRC_FETCH: begin
                    issue_valid_o  <= 1'b1;
                    issue_instr_o  <= fetch_instr_i;
                    issue_pc_o     <= fetch_pc_i;
                    issue_npc_o    <= fetch_npc_i;
                    issue_is_uop_o <= 1'b0;
                end
                default: begin
                    issue_valid_o  <= 1'b0;
                    issue_instr_o  <= NOP_INSTR;
                    issue_is_uop_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        uop_overflow_o <= 1'b0;
        else if (fifo_drop) uop_overflow_o <= 1'b1;
    end
endmodule

// File: tb/tb_decode_issue_seq.sv
// Bench for decode_issue_seq: two instances (delay 2/depth 4 and delay 0/depth 1) share stimulus.
module tb_decode_issue_seq;
    import decode_pkg::*;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni, fetch_valid_i, uop_push_i, stall_i, flush_i;
    instr_t      fetch_instr_i, uop_i;
    logic [31:0] fetch_pc_i, fetch_npc_i;

    logic        rdy [2];
    logic        vld [2];
    instr_t      ins [2];
    logic [31:0] pc  [2];
    logic [31:0] npc [2];
    logic        isu [2];
    logic        full[2];
    logic        ovf [2];
    logic [2:0]  cnt0;
    logic [0:0]  cnt1;

    decode_issue_seq #(.UOP_DELAY(2), .UOP_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(rdy[0]), .fetch_instr_i(fetch_instr_i),
        .fetch_pc_i(fetch_pc_i), .fetch_npc_i(fetch_npc_i),
        .uop_push_i(uop_push_i), .uop_i(uop_i), .stall_i(stall_i), .flush_i(flush_i),
        .issue_valid_o(vld[0]), .issue_instr_o(ins[0]), .issue_pc_o(pc[0]), .issue_npc_o(npc[0]),
        .issue_is_uop_o(isu[0]), .uop_count_o(cnt0), .uop_full_o(full[0]), .uop_overflow_o(ovf[0])
    );

    decode_issue_seq #(.UOP_DELAY(0), .UOP_DEPTH(1)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(rdy[1]), .fetch_instr_i(fetch_instr_i),
        .fetch_pc_i(fetch_pc_i), .fetch_npc_i(fetch_npc_i),
        .uop_push_i(uop_push_i), .uop_i(uop_i), .stall_i(stall_i), .flush_i(flush_i),
        .issue_valid_o(vld[1]), .issue_instr_o(ins[1]), .issue_pc_o(pc[1]), .issue_npc_o(npc[1]),
        .issue_is_uop_o(isu[1]), .uop_count_o(cnt1), .uop_full_o(full[1]), .uop_overflow_o(ovf[1])
    );

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;
    logic pre_rdy0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: pending uops carry a countdown of non-stalled edges until they
    // land in the queue; the queue is a plain array with front removal.
    int          MDEL [2] = '{2, 0};
    int          MDEP [2] = '{4, 1};
    instr_t      mq   [2][8];
    int          mcnt [2];
    instr_t      pi   [2][8];
    int          pl   [2][8];
    int          pn   [2];
    logic        mv [2], mu [2], movf [2];
    instr_t      mins [2];
    logic [31:0] mpc [2], mnpc [2];

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; pn[i] = 0; mv[i] = 0; mu[i] = 0; movf[i] = 0;
            mins[i] = NOP_INSTR; mpc[i] = 0; mnpc[i] = 0;
        end
    endtask

    function automatic logic exp_rdy(input int i);
        return !stall_i && !flush_i && (mcnt[i] == 0);
    endfunction

    task automatic mstep(input int i);
        logic beat;
        beat = fetch_valid_i && exp_rdy(i);
        if (flush_i) begin
            pn[i] = 0; mcnt[i] = 0; mv[i] = 0; mu[i] = 0; mins[i] = NOP_INSTR;
        end else if (!stall_i) begin
            if (mcnt[i] > 0) begin
                mins[i] = mq[i][0]; mu[i] = 1; mv[i] = 1;
                for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                mcnt[i]--;
            end else if (beat) begin
                mins[i] = fetch_instr_i; mpc[i] = fetch_pc_i; mnpc[i] = fetch_npc_i;
                mu[i] = 0; mv[i] = 1;
            end else begin
                mins[i] = NOP_INSTR; mu[i] = 0; mv[i] = 0;
            end
            if (uop_push_i) begin
                pi[i][pn[i]] = uop_i; pl[i][pn[i]] = MDEL[i] + 1; pn[i]++;
            end
            for (int k = 0; k < pn[i]; k++) pl[i][k]--;
            if (pn[i] > 0 && pl[i][0] == 0) begin
                if (mcnt[i] < MDEP[i]) begin
                    mq[i][mcnt[i]] = pi[i][0]; mcnt[i]++;
                end else begin
                    movf[i] = 1;
                end
                for (int k = 0; k < 7; k++) begin
                    pi[i][k] = pi[i][k+1]; pl[i][k] = pl[i][k+1];
                end
                pn[i]--;
            end
        end
    endtask

    // Inputs must already be driven; returns 1 time unit after the edge.
    task automatic step();
        #1;
        pre_rdy0 = rdy[0];
        for (int i = 0; i < 2; i++) chk($sformatf("ready[%0d]", i), rdy[i], exp_rdy(i));
        @(posedge clk_i);
        for (int i = 0; i < 2; i++) mstep(i);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid[%0d]", i), vld[i], mv[i]);
            chk($sformatf("instr[%0d]", i), ins[i], mins[i]);
            chk($sformatf("is_uop[%0d]", i), isu[i], mu[i]);
            chk($sformatf("pc[%0d]", i), pc[i], mpc[i]);
            chk($sformatf("npc[%0d]", i), npc[i], mnpc[i]);
            chk($sformatf("full[%0d]", i), full[i], mcnt[i] == MDEP[i]);
            chk($sformatf("overflow[%0d]", i), ovf[i], movf[i]);
        end
        chk("count[0]", cnt0, mcnt[0]);
        chk("count[1]", cnt1, mcnt[1]);
    endtask

    task automatic rst_chk(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s valid[%0d]", tag, i), vld[i], 1'b0);
            chk($sformatf("%s instr[%0d]", tag, i), ins[i], 16'h000F);
            chk($sformatf("%s is_uop[%0d]", tag, i), isu[i], 1'b0);
            chk($sformatf("%s pc[%0d]", tag, i), pc[i], 32'h0);
            chk($sformatf("%s npc[%0d]", tag, i), npc[i], 32'h0);
            chk($sformatf("%s overflow[%0d]", tag, i), ovf[i], 1'b0);
        end
        chk({tag, " count[0]"}, cnt0, 3'd0);
        chk({tag, " count[1]"}, cnt1, 1'b0);
    endtask

    task automatic idle_inputs();
        fetch_valid_i = 0; fetch_instr_i = '0; fetch_pc_i = 0; fetch_npc_i = 0;
        uop_push_i = 0; uop_i = '0; stall_i = 0; flush_i = 0;
    endtask

    typedef struct {
        logic fv; instr_t fi; logic [31:0] fpc, fnpc; logic up; instr_t u; logic st, fl;
        logic rdy, v; instr_t ins; logic isu; logic [31:0] pc; int cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic addv(input logic fv, input instr_t fi, input logic [31:0] fpc, input logic [31:0] fnpc,
                        input logic up, input instr_t u, input logic st, input logic fl,
                        input logic rdy, input logic v, input instr_t ei, input logic isu_e,
                        input logic [31:0] epc, input int ecnt);
        vec_t r;
        r.fv = fv; r.fi = fi; r.fpc = fpc; r.fnpc = fnpc; r.up = up; r.u = u; r.st = st; r.fl = fl;
        r.rdy = rdy; r.v = v; r.ins = ei; r.isu = isu_e; r.pc = epc; r.cnt = ecnt;
        tbl.push_back(r);
    endtask

    initial begin
        // Expected values are for the delay-2 / depth-4 instance.
        //   fv fi        pc  npc  up uop       st fl  rdy v ins       uop pc  cnt
        addv(1, 16'hA000, 0,  2,   0, 16'h0,    0, 0,  1, 1, 16'hA000, 0,  0,  0);
        addv(1, 16'hA001, 2,  4,   1, 16'hB500, 0, 0,  1, 1, 16'hA001, 0,  2,  0);
        addv(1, 16'hA002, 4,  6,   0, 16'h0,    0, 0,  1, 1, 16'hA002, 0,  4,  0);
        addv(1, 16'hA003, 6,  8,   0, 16'h0,    0, 0,  1, 1, 16'hA003, 0,  6,  1);
        addv(1, 16'hA004, 8,  10,  0, 16'h0,    0, 0,  0, 1, 16'hB500, 1,  6,  0);
        addv(1, 16'hA004, 8,  10,  0, 16'h0,    0, 0,  1, 1, 16'hA004, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   1, 16'hC000, 0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   1, 16'hC001, 0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   1, 16'hC002, 0, 0,  1, 0, 16'h000F, 0,  8,  1);
        addv(0, 16'h0,    0,  0,   1, 16'hC003, 0, 0,  0, 1, 16'hC000, 1,  8,  1);
        addv(0, 16'h0,    0,  0,   1, 16'hC004, 1, 0,  0, 1, 16'hC000, 1,  8,  1);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    1, 0,  0, 1, 16'hC000, 1,  8,  1);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  0, 1, 16'hC001, 1,  8,  1);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  0, 1, 16'hC002, 1,  8,  1);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  0, 1, 16'hC003, 1,  8,  0);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   1, 16'hD000, 0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   1, 16'hD001, 0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   1, 16'hD002, 0, 0,  1, 0, 16'h000F, 0,  8,  1);
        addv(1, 16'hA00F, 16, 18,  1, 16'hE000, 1, 1,  0, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(0, 16'h0,    0,  0,   0, 16'h0,    0, 0,  1, 0, 16'h000F, 0,  8,  0);
        addv(1, 16'hA010, 32, 34,  0, 16'h0,    0, 0,  1, 1, 16'hA010, 0,  32, 0);

        idle_inputs();
        rst_ni = 1'b0;
        mreset();
        repeat (2) @(posedge clk_i);
        #2;
        rst_chk("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (tbl[n]) begin
            fetch_valid_i = tbl[n].fv; fetch_instr_i = tbl[n].fi;
            fetch_pc_i = tbl[n].fpc; fetch_npc_i = tbl[n].fnpc;
            uop_push_i = tbl[n].up; uop_i = tbl[n].u; stall_i = tbl[n].st; flush_i = tbl[n].fl;
            step();
            chk($sformatf("row%0d ready", n), pre_rdy0, tbl[n].rdy);
            chk($sformatf("row%0d valid", n), vld[0], tbl[n].v);
            chk($sformatf("row%0d instr", n), ins[0], tbl[n].ins);
            chk($sformatf("row%0d is_uop", n), isu[0], tbl[n].isu);
            chk($sformatf("row%0d pc", n), pc[0], tbl[n].pc);
            chk($sformatf("row%0d count", n), cnt0, tbl[n].cnt);
        end

        for (int n = 0; n < 600; n++) begin
            fetch_valid_i = ($urandom_range(3) != 0);
            fetch_instr_i = instr_t'($urandom);
            fetch_pc_i    = $urandom;
            fetch_npc_i   = $urandom;
            uop_push_i    = ($urandom_range(2) == 0);
            uop_i         = instr_t'($urandom);
            stall_i       = ($urandom_range(4) == 0);
            flush_i       = ($urandom_range(19) == 0);
            step();
            if (n == 300) begin
                // Asynchronous reset between edges: outputs must clear before the next edge.
                #2;
                rst_ni = 1'b0;
                #1;
                rst_chk("async reset");
                mreset();
                @(negedge clk_i);
                rst_ni = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
